hazard_ctrl: RTL and testbench

Central pipeline hazard controller for the 5-stage MIPS core. Each cycle it produces the stall, flush and PC-write controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch/jump redirects and multi-cycle data-memory waits. A small FSM sequences multi-cycle flush windows and memory-wait timeouts.

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_loaduse_detect.sv | 18 +
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 130 +++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM states and architectural constants.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'b0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline hazard sources in, register controls out.
// master = pipeline datapath side, slave = hazard controller.
interface hazard_ctrl_if #(parameter int CNT_W = 16);

    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             ex_redirect;
    logic             dmem_busy;

    logic             pc_write;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_stall;
    logic             idex_flush;
    logic             exmem_stall;
    logic             memwb_flush;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_redirect, dmem_busy,
        input  pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_flush, mem_timeout_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_redirect, dmem_busy,
        output pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_flush, mem_timeout_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_loaduse_detect.sv
// Combinational load-use compare: a load in EX writes a register that the
// instruction in ID reads. $zero never creates a dependency.
// Also instantiated by the forwarding unit.
module hazard_loaduse_detect
    import pipeline_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);

    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline hazard controller: Mealy stall/flush/PC-write controls for
// load-use bubbles, branch/jump redirects and data-memory waits.
// Optional macro HAZARD_PERF_CNT_EN builds saturating stall/flush counters;
// without it stall_cnt/flush_cnt are tied to zero.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,   // 1..3
    parameter int MEM_TIMEOUT  = 16,  // 2..255
    parameter int CNT_W        = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    localparam logic [1:0]       FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [7:0]       WAIT_LAST    = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = '0;

    state_t     state, state_nx, ret_state, ret_state_nx, mode;
    logic [1:0] flush_left, flush_left_nx;
    logic [7:0] wait_cnt, wait_cnt_nx;
    logic       err, err_set;
    logic       load_use;

    logic pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush;

    hazard_loaduse_detect u_loaduse (
        .ex_mem_read (hz.ex_mem_read),
        .ex_rt       (hz.ex_rt),
        .id_rs       (hz.id_rs),
        .id_rt       (hz.id_rt),
        .id_uses_rt  (hz.id_uses_rt),
        .load_use    (load_use)
    );

    // Control outputs and next-state: freeze dominates, then redirect, then load-use.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        pc_write      = 1'b1;
        ifid_stall    = 1'b0;
        ifid_flush    = 1'b0;
        idex_stall    = 1'b0;
        idex_flush    = 1'b0;
        exmem_stall   = 1'b0;
        memwb_flush   = 1'b0;
        state_nx      = state;
        ret_state_nx  = ret_state;
        flush_left_nx = flush_left;
        wait_cnt_nx   = wait_cnt;
        err_set       = 1'b0;

        // A wait that ends this cycle behaves like the state it interrupted.
        mode = (state == MEM_WAIT && !hz.dmem_busy) ? ret_state : state;

        if (state == HALT || hz.dmem_busy) begin
            pc_write    = 1'b0;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
            if (state == MEM_WAIT) begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nx = HALT;
                    err_set  = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + 8'd1;
                end
            end else if (state != HALT) begin
                // Entering a wait from RUN or FLUSH; flush_left is kept as is.
                ret_state_nx = state;
                wait_cnt_nx  = 8'd1;
                state_nx     = MEM_WAIT;
            end
        end else if (mode == FLUSH) begin
            // ID already holds a NOP here, so load-use is not checked.
            ifid_flush = 1'b1;
            if (hz.ex_redirect) begin
                idex_flush    = 1'b1;
                flush_left_nx = FLUSH_RELOAD;
                state_nx      = (FLUSH_RELOAD != 2'd0) ? FLUSH : RUN;
            end else begin
                flush_left_nx = (flush_left != 2'd0) ? flush_left - 2'd1 : 2'd0;
                state_nx      = (flush_left <= 2'd1) ? RUN : FLUSH;
            end
        end else begin
            state_nx = RUN;
            if (hz.ex_redirect) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (FLUSH_RELOAD != 2'd0) begin
                    flush_left_nx = FLUSH_RELOAD;
                    state_nx      = FLUSH;
                end
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    // FSM registers and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            ret_state  <= RUN;
            flush_left <= 2'd0;
            wait_cnt   <= 8'd0;
            err        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state      <= state_nx;
            ret_state  <= ret_state_nx;
            flush_left <= flush_left_nx;
            wait_cnt   <= wait_cnt_nx;
            if (err_set) err <= 1'b1;
        end
    end

    assign hz.pc_write        = pc_write;
    assign hz.ifid_stall      = ifid_stall;
    assign hz.ifid_flush      = ifid_flush;
    assign hz.idex_stall      = idex_stall;
    assign hz.idex_flush      = idex_flush;
    assign hz.exmem_stall     = exmem_stall;
    assign hz.memwb_flush     = memwb_flush;
    assign hz.mem_timeout_err = err;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // Saturating performance counters for stalled-PC and IF/ID-flush cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= CNT_ZERO;
            flush_cnt <= CNT_ZERO;
        end else begin
            if (!pc_write && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hz.stall_cnt = stall_cnt;
    assign hz.flush_cnt = flush_cnt;
`else
    assign hz.stall_cnt = CNT_ZERO;
    assign hz.flush_cnt = CNT_ZERO;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYCLES=3, MEM_TIMEOUT=16).
module tb_hazard_ctrl;

    // Control vector order: pc_write, ifid_stall, ifid_flush, idex_stall,
    // idex_flush, exmem_stall, memwb_flush.
    localparam logic [6:0] DEF = 7'b1000000;
    localparam logic [6:0] FRZ = 7'b0101011;
    localparam logic [6:0] LU  = 7'b0100100;
    localparam logic [6:0] RD  = 7'b1010100;
    localparam logic [6:0] FL  = 7'b1010000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) hz ();

    hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    wire [6:0] ctrl = {hz.pc_write, hz.ifid_stall, hz.ifid_flush, hz.idex_stall,
                       hz.idex_flush, hz.exmem_stall, hz.memwb_flush};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then let outputs settle.
    task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mr, input logic [4:0] ert, input logic redir,
                       input logic busy);
        @(negedge clk);
        hz.id_rs       = rs;
        hz.id_rt       = rt;
        hz.id_uses_rt  = urt;
        hz.ex_mem_read = mr;
        hz.ex_rt       = ert;
        hz.ex_redirect = redir;
        hz.dmem_busy   = busy;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rt = 0; hz.ex_mem_read = 0;
        hz.ex_rt = '0; hz.ex_redirect = 0; hz.dmem_busy = 0;
        #1;
        check("reset_ctrl", 16'(ctrl), 16'(DEF));
        check("reset_err", 16'(hz.mem_timeout_err), 16'd0);
        check("reset_stall_cnt", hz.stall_cnt, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Load-use on rs: one-cycle bubble.
        cyc(5'd8, 5'd0, 0, 1, 5'd8, 0, 0);  check("lu_rs", 16'(ctrl), 16'(LU));
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0);  check("lu_rs_after", 16'(ctrl), 16'(DEF));
        // Load-use via rt only when rt is read.
        cyc(5'd3, 5'd9, 1, 1, 5'd9, 0, 0);  check("lu_rt", 16'(ctrl), 16'(LU));
        cyc(5'd3, 5'd9, 0, 1, 5'd9, 0, 0);  check("lu_rt_unused", 16'(ctrl), 16'(DEF));
        // $zero destination never stalls.
        cyc(5'd0, 5'd0, 1, 1, 5'd0, 0, 0);  check("lu_zero", 16'(ctrl), 16'(DEF));

        // Redirect: 3 cycles of ifid_flush, 1 of idex_flush; load-use ignored in FLUSH.
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 1, 0);  check("redir_c1", 16'(ctrl), 16'(RD));
        cyc(5'd8, 5'd0, 0, 1, 5'd8, 0, 0);  check("redir_c2_lu_ignored", 16'(ctrl), 16'(FL));
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0);  check("redir_c3", 16'(ctrl), 16'(FL));
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0);  check("redir_done", 16'(ctrl), 16'(DEF));

`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_cnt", hz.stall_cnt, 16'd2);
        check("perf_flush_cnt", hz.flush_cnt, 16'd3);
`else
        check("perf_stall_cnt_off", hz.stall_cnt, 16'd0);
        check("perf_flush_cnt_off", hz.flush_cnt, 16'd0);
`endif

        // Short memory wait: exactly 5 frozen cycles, no error.
        for (int i = 1; i <= 5; i++) begin
            cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 1);
            check($sformatf("busy5_c%0d", i), 16'(ctrl), 16'(FRZ));
        end
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0);  check("busy5_release", 16'(ctrl), 16'(DEF));
        check("busy5_err", 16'(hz.mem_timeout_err), 16'd0);

        // Redirect, then a 4-cycle wait on the 2nd FLUSH-state cycle.
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 1, 0);  check("rw_redir", 16'(ctrl), 16'(RD));
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0);  check("rw_flush1", 16'(ctrl), 16'(FL));
        for (int i = 1; i <= 4; i++) begin
            cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 1);
            check($sformatf("rw_freeze%0d", i), 16'(ctrl), 16'(FRZ));
        end
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0);  check("rw_last_flush", 16'(ctrl), 16'(FL));
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0);  check("rw_done", 16'(ctrl), 16'(DEF));

        // Timeout: 16 busy cycles enter HALT at the edge ending the 16th.
        for (int i = 1; i <= 16; i++) begin
            cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 1);
            check($sformatf("to_busy%0d", i), 16'(ctrl), 16'(FRZ));
            if (i == 16) check("to_err_before", 16'(hz.mem_timeout_err), 16'd0);
        end
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0);  check("halt_ctrl", 16'(ctrl), 16'(FRZ));
        check("halt_err", 16'(hz.mem_timeout_err), 16'd1);
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 1, 0);  check("halt_ignores_redir", 16'(ctrl), 16'(FRZ));

        // Asynchronous reset leaves HALT immediately.
        @(negedge clk);
        hz.ex_redirect = 0;
        reset = 1'b1;
        #1;
        check("rst_halt_ctrl", 16'(ctrl), 16'(DEF));
        check("rst_halt_err", 16'(hz.mem_timeout_err), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0);  check("post_rst", 16'(ctrl), 16'(DEF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
